// File: rtl/mult_result_serializer.sv
// Queues multiplier products and shifts each one out MSB-first, one bit per bit_en strobe.
// Define MULT_SER_PARITY_EN to append an even-parity bit after each product LSB.
module mult_result_serializer #(
  parameter int width = 4,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*width-1:0]     res,
  input  logic                   done,
  input  logic                   bit_en,
  output logic                   miso,
  output logic                   busy,
  output logic                   frame_done,
  output logic [$clog2(depth):0] count,
  output logic                   overflow
);
  localparam int PW = 2 * width;
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
`ifdef MULT_SER_PARITY_EN
  localparam int FW = PW + 1;
`else
  localparam int FW = PW;
`endif
  localparam int BW = $clog2(FW + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q;
  logic [PW-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [FW-1:0] shreg_q;
  logic [FW-1:0] load_word;
  logic [BW-1:0] bitcnt_q;
  logic          frame_done_q;
  logic [PW-1:0] head;
  logic          full, pop, push;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    full       = (count_q == CW'(depth));
    pop        = (state_q == IDLE) && (count_q != '0);
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    push       = done && (!full || pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (done & ~push);
`ifdef MULT_SER_PARITY_EN
    load_word  = {head, ^head};
`else
    load_word  = head;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q  <= load_word;
            bitcnt_q <= BW'(FW);
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          // Zero fill leaves shreg_q clear once the frame ends, so miso idles low.
          if (bit_en) begin
            shreg_q  <= {shreg_q[FW-2:0], 1'b0};
            bitcnt_q <= bitcnt_q - BW'(1);
            if (bitcnt_q == BW'(1)) begin
              state_q      <= IDLE;
              frame_done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign miso       = shreg_q[FW-1];
  assign busy       = (state_q == SHIFT);
  assign frame_done = frame_done_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
endmodule
